// File: rtl/rr_trace_write_ctrl.sv
// -----------------------------------------------------------------------------
// rr_trace_write_ctrl
//
// Trace-ring write controller. Packed logging beats from the merge tree go
// straight through to the write port with no added latency. The controller
// generates a byte address inside a ring buffer. When the ring fills, it either
// wraps back to the base or stops. It also limits the number of writes that are
// in flight but not yet acknowledged.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   cfg_base             ring base byte address (sampled on accepted start)
//   cfg_size_beats       ring size in beats (sampled on accepted start, 0 = reject)
//   cfg_wrap             1 = wrap at end of ring, 0 = stop when full
//   cfg_start/cfg_stop   single-cycle control pulses
//   in_valid/in_ready    logging beat handshake, in_data is the beat payload
//   wr_valid/wr_ready    write issue handshake, wr_addr/wr_data describe it
//   wr_resp              one pulse per completed write
//   st_*                 status: FSM state, beat/wrap counters, outstanding
//                        writes, full/done flags, sticky response error
// -----------------------------------------------------------------------------
module rr_trace_write_ctrl #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 16,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [31:0]           cfg_size_beats,
    input  logic                  cfg_wrap,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    input  logic                  wr_resp,
    output logic [1:0]            st_state,
    output logic [31:0]           st_beats,
    output logic [31:0]           st_wraps,
    output logic [OW-1:0]         st_outstanding,
    output logic                  st_full,
    output logic                  st_done,
    output logic                  st_err
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_offset;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_size;
    logic                  r_wrap;
    logic [31:0]           r_beats;
    logic [31:0]           r_wraps;
    logic [OW-1:0]         r_out;
    logic                  r_full;
    logic                  r_err;

    logic                  w_start_ok;
    logic                  w_issue_ok;
    logic                  w_issue;
    logic                  w_last;

    // A start is honoured only from an idle or finished ring with a non-empty size.
    assign w_start_ok = cfg_start && (cfg_size_beats != 32'd0) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_issue_ok = (r_state == ST_RUN) && (r_out < OW'(MAX_OUTSTANDING));
    assign w_issue    = wr_valid && wr_ready;
    // The current issue lands in the final slot of the ring.
    assign w_last     = (r_offset == (r_size - 32'd1));

    // The write port passes the input through combinationally; back-pressure comes from the sink.
    assign wr_valid = in_valid && w_issue_ok;
    assign in_ready = wr_ready && w_issue_ok;
    assign wr_data  = in_data;
    assign wr_addr  = r_addr;

    assign st_state       = r_state;
    assign st_beats       = r_beats;
    assign st_wraps       = r_wraps;
    assign st_outstanding = r_out;
    assign st_full        = r_full;
    assign st_done        = (r_state == ST_DONE);
    assign st_err         = r_err;

    // Next-state selection for the ring control FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A non-wrapping ring that just filled its last slot stops like a stop request.
                if (w_issue && w_last && !r_wrap) begin
                    w_next_state = ST_DRAIN;
                end else if (cfg_stop) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_out == '0) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (w_start_ok) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the ring configuration and advance the write address and ring offset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr   <= '0;
            r_offset <= 32'd0;
            r_base   <= '0;
            r_size   <= 32'd0;
            r_wrap   <= 1'b0;
        end else if (w_start_ok) begin
            r_addr   <= cfg_base;
            r_offset <= 32'd0;
            r_base   <= cfg_base;
            r_size   <= cfg_size_beats;
            r_wrap   <= cfg_wrap;
        end else if (w_issue) begin
            if (w_last && r_wrap) begin
                r_addr   <= r_base;
                r_offset <= 32'd0;
            end else begin
                r_addr   <= r_addr + ADDR_WIDTH'(BEAT_BYTES);
                r_offset <= r_offset + 32'd1;
            end
        end else begin
            r_addr   <= r_addr;
            r_offset <= r_offset;
        end
    end

    // Beat and wrap counters (saturating) and the ring-full flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beats <= 32'd0;
            r_wraps <= 32'd0;
            r_full  <= 1'b0;
        end else if (w_start_ok) begin
            r_beats <= 32'd0;
            r_wraps <= 32'd0;
            r_full  <= 1'b0;
        end else if (w_issue) begin
            if (r_beats != 32'hFFFF_FFFF) begin
                r_beats <= r_beats + 32'd1;
            end else begin
                r_beats <= r_beats;
            end
            if (w_last && r_wrap && (r_wraps != 32'hFFFF_FFFF)) begin
                r_wraps <= r_wraps + 32'd1;
            end else begin
                r_wraps <= r_wraps;
            end
            if (w_last && !r_wrap) begin
                r_full <= 1'b1;
            end else begin
                r_full <= r_full;
            end
        end else begin
            r_beats <= r_beats;
            r_wraps <= r_wraps;
            r_full  <= r_full;
        end
    end

    // Outstanding-write credit counter. It counts in every state so that a drain can finish.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
        end else if (w_issue && !wr_resp) begin
            r_out <= r_out + OW'(1);
        end else if (!w_issue && wr_resp && (r_out != '0)) begin
            r_out <= r_out - OW'(1);
        end else begin
            r_out <= r_out;
        end
    end

    // Sticky error for a response that has no matching outstanding write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (wr_resp && !w_issue && (r_out == '0)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

endmodule

// File: tb/tb_rr_trace_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_trace_write_ctrl
//
// Directed-vector bench for the trace-ring write controller. It uses 64-byte
// beats and allows four outstanding writes. Inputs change 1 ns after the rising
// edge. Combinational outputs are sampled 1 ns after that, and registered
// outputs are sampled after the following edge.
// -----------------------------------------------------------------------------
module tb_rr_trace_write_ctrl;

    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int MO  = 4;
    localparam int OW  = $clog2(MO + 1);

    logic          clk;
    logic          rstn;
    logic [AW-1:0] cfg_base;
    logic [31:0]   cfg_size_beats;
    logic          cfg_wrap;
    logic          cfg_start;
    logic          cfg_stop;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_resp;
    logic [1:0]    st_state;
    logic [31:0]   st_beats;
    logic [31:0]   st_wraps;
    logic [OW-1:0] st_outstanding;
    logic          st_full;
    logic          st_done;
    logic          st_err;

    int n_checks;
    int n_pass;

    rr_trace_write_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_base      (cfg_base),
        .cfg_size_beats(cfg_size_beats),
        .cfg_wrap      (cfg_wrap),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .wr_resp       (wr_resp),
        .st_state      (st_state),
        .st_beats      (st_beats),
        .st_wraps      (st_wraps),
        .st_outstanding(st_outstanding),
        .st_full       (st_full),
        .st_done       (st_done),
        .st_err        (st_err)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios.
    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rstn           = 1'b0;
        cfg_base       = 64'd0;
        cfg_size_beats = 32'd0;
        cfg_wrap       = 1'b0;
        cfg_start      = 1'b0;
        cfg_stop       = 1'b0;
        in_valid       = 1'b1;
        in_data        = '0;
        wr_ready       = 1'b1;
        wr_resp        = 1'b0;

        // Reset state, with valid/ready held high to show they are masked.
        #12;
        check("rst_state",    64'(st_state), 64'd0);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_done",     64'(st_done),  64'd0);
        in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Non-wrapping ring of 4 beats at 0x1000.
        cfg_base       = 64'h1000;
        cfg_size_beats = 32'd4;
        cfg_wrap       = 1'b0;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
        cfg_base       = 64'hDEAD_0000;  // later config changes must be ignored
        cfg_wrap       = 1'b1;
        check("t1_run", 64'(st_state), 64'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_resp = (i != 0);
            in_data = DW'(64'hA000 + 64'(i));
            #1;
            check("t1_addr",   wr_addr, 64'h1000 + 64'(i) * 64'h40);
            check("t1_data",   wr_data[63:0], 64'hA000 + 64'(i));
            check("t1_ready",  64'(in_ready), 64'd1);
            tick();
        end
        wr_resp = 1'b1;
        #1;
        check("t1_drain",     64'(st_state), 64'd2);
        check("t1_5th_valid", 64'(wr_valid), 64'd0);
        check("t1_5th_ready", 64'(in_ready), 64'd0);
        check("t1_full",      64'(st_full),  64'd1);
        tick();
        wr_resp = 1'b0;
        check("t1_drain2", 64'(st_state), 64'd2);
        tick();
        check("t1_done_state", 64'(st_state),       64'd3);
        check("t1_done",       64'(st_done),        64'd1);
        check("t1_beats",      st_beats,            64'd4);
        check("t1_out",        64'(st_outstanding), 64'd0);
        check("t1_err",        64'(st_err),         64'd0);
        in_valid = 1'b0;

        // Wrapping ring of 2 beats, 5 beats written.
        cfg_base       = 64'h2000;
        cfg_size_beats = 32'd2;
        cfg_wrap       = 1'b1;
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("t2_run",     64'(st_state), 64'd1);
        check("t2_donecl",  64'(st_done),  64'd0);
        check("t2_fullcl",  64'(st_full),  64'd0);
        check("t2_beatscl", st_beats,      64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_resp = (i != 0);
            #1;
            check("t2_addr", wr_addr, ((i % 2) == 1) ? 64'h2040 : 64'h2000);
            tick();
        end
        in_valid = 1'b0;
        wr_resp  = 1'b1;
        tick();
        wr_resp = 1'b0;
        check("t2_wraps", st_wraps,            64'd2);
        check("t2_state", 64'(st_state),       64'd1);
        check("t2_beats", st_beats,            64'd5);
        check("t2_out",   64'(st_outstanding), 64'd0);

        // Credit limit of 4 with no responses.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_issue", 64'(wr_valid), 64'd1);
            tick();
        end
        check("t3_out4",   64'(st_outstanding), 64'd4);
        check("t3_nvalid", 64'(wr_valid),       64'd0);
        check("t3_nready", 64'(in_ready),       64'd0);
        wr_resp = 1'b1;
        tick();
        wr_resp = 1'b0;
        #1;
        check("t3_one_more", 64'(wr_valid), 64'd1);
        tick();
        tick();
        check("t3_blocked", 64'(wr_valid),       64'd0);
        check("t3_out_b",   64'(st_outstanding), 64'd4);
        check("t3_beats",   st_beats,            64'd10);

        // Stop on an issue cycle with 3 outstanding.
        in_valid = 1'b0;
        wr_resp  = 1'b1;
        tick();
        wr_resp = 1'b0;
        check("t4_out3", 64'(st_outstanding), 64'd3);
        in_valid = 1'b1;
        cfg_stop = 1'b1;
        #1;
        check("t4_stop_issue", 64'(wr_valid), 64'd1);
        tick();
        cfg_stop = 1'b0;
        check("t4_drain", 64'(st_state),       64'd2);
        check("t4_beats", st_beats,            64'd11);
        check("t4_out4",  64'(st_outstanding), 64'd4);
        check("t4_nvalid", 64'(wr_valid),      64'd0);
        for (int k = 0; k < 4; k++) begin
            wr_resp = 1'b1;
            tick();
            check("t4_hold", 64'(st_state), 64'd2);
        end
        wr_resp = 1'b0;
        tick();
        check("t4_done", 64'(st_state), 64'd3);
        check("t4_dflag", 64'(st_done), 64'd1);

        // Reset mid-RUN with 2 outstanding.
        in_valid       = 1'b0;
        cfg_base       = 64'h3000;
        cfg_size_beats = 32'd8;
        cfg_wrap       = 1'b0;
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        check("t6_pre_out", 64'(st_outstanding), 64'd2);
        rstn = 1'b0;
        #1;
        check("t6_state",  64'(st_state),       64'd0);
        check("t6_out",    64'(st_outstanding), 64'd0);
        check("t6_beats",  st_beats,            64'd0);
        check("t6_addr",   wr_addr,             64'd0);
        check("t6_valid",  64'(wr_valid),       64'd0);
        check("t6_ready",  64'(in_ready),       64'd0);
        in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Stray response in IDLE, a rejected zero-size start, then a good start.
        wr_resp = 1'b1;
        tick();
        wr_resp = 1'b0;
        check("t5_err",   64'(st_err),         64'd1);
        check("t5_out",   64'(st_outstanding), 64'd0);
        check("t5_idle",  64'(st_state),       64'd0);
        cfg_size_beats = 32'd0;
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("t5_zero_ign", 64'(st_state), 64'd0);
        check("t5_err_kept", 64'(st_err),   64'd1);
        cfg_size_beats = 32'd4;
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("t5_run",    64'(st_state), 64'd1);
        check("t5_err_cl", 64'(st_err),   64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
